// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch and a
// load/store requester, with a per-transaction BUSY timeout.
module mem_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_ack,
    output logic             if_err,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_ack,
    output logic             ls_err,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_valid
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             last_grant, last_grant_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             mem_we_next;
    logic [WIDTH-1:0] mem_addr_next, mem_wdata_next;
    logic [WIDTH-1:0] if_rdata_next, ls_rdata_next;
    logic             if_err_next, ls_err_next;
    logic             grant_ls;

    // Next-state, grant latching and response capture
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        cnt_next        = cnt;
        mem_we_next     = mem_we;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        if_rdata_next   = if_rdata;
        ls_rdata_next   = ls_rdata;
        if_err_next     = if_err;
        ls_err_next     = ls_err;
        // LS wins when alone, or on contention when IF was served last
        grant_ls        = ls_req && (!if_req || !last_grant);

        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_next      = BUSY;
                    owner_next      = grant_ls;
                    last_grant_next = grant_ls;
                    cnt_next        = '0;
                    if (grant_ls) begin
                        mem_addr_next  = ls_addr;
                        mem_we_next    = ls_we;
                        mem_wdata_next = ls_wdata;
                    end else begin
                        mem_addr_next  = if_addr;
                        mem_we_next    = 1'b0;
                        mem_wdata_next = '0;
                    end
                end
            end
            BUSY: begin
                // A completion on the final counted cycle still wins over the timeout
                if (mem_valid) begin
                    state_next = RESP;
                    if (owner) begin
                        ls_rdata_next = mem_rdata;
                        ls_err_next   = 1'b0;
                    end else begin
                        if_rdata_next = mem_rdata;
                        if_err_next   = 1'b0;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_next = RESP;
                    if (owner) begin
                        ls_rdata_next = '0;
                        ls_err_next   = 1'b1;
                    end else begin
                        if_rdata_next = '0;
                        if_err_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            if_err     <= 1'b0;
            ls_err     <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            cnt        <= cnt_next;
            mem_req    <= (state_next == BUSY);
            mem_we     <= mem_we_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            if_ack     <= (state_next == RESP) && !owner_next;
            ls_ack     <= (state_next == RESP) && owner_next;
            if_err     <= if_err_next;
            ls_err     <= ls_err_next;
            if_rdata   <= if_rdata_next;
            ls_rdata   <= ls_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_mem_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req, if_ack, if_err;
    logic [W-1:0] if_addr, if_rdata;
    logic         ls_req, ls_we, ls_ack, ls_err;
    logic [W-1:0] ls_addr, ls_wdata, ls_rdata;
    logic         mem_req, mem_we, mem_valid;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ack    (ls_ack),
        .ls_err    (ls_err),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_ack, ls_ack, if_err, ls_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 000000", {mem_req, mem_we, if_ack, ls_ack, if_err, ls_err});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({if_rdata, ls_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got if=%h ls=%h exp 0", if_rdata, ls_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_mem_req: got %b exp 0", mem_req);
        end
    endtask

    task automatic test_if_only();
        if_req = 1'b1; if_addr = 32'h0000_3000;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h3000, 32'h0}) begin
            errors++;
            $display("FAIL if_only_bus: got req=%b we=%b addr=%h wdata=%h exp 1 0 3000 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL if_only_hold: got mem_req=%b exp 1", mem_req);
        end
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_valid = 1'b0; if_req = 1'b0;
        checks++;
        if ({mem_req, if_ack, ls_ack, if_err, if_rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h13}) begin
            errors++;
            $display("FAIL if_only_ack: got req=%b if_ack=%b ls_ack=%b err=%b rdata=%h exp 0 1 0 0 13", mem_req, if_ack, ls_ack, if_err, if_rdata);
        end
        @(negedge clk);
        checks++;
        if ({if_ack, mem_req, if_rdata} !== {1'b0, 1'b0, 32'h13}) begin
            errors++;
            $display("FAIL if_only_after: got ack=%b req=%b rdata=%h exp 0 0 13", if_ack, mem_req, if_rdata);
        end
    endtask

    task automatic test_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h exp 1 1 100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_valid = 1'b1; mem_rdata = 32'h0000_5A5A;
        @(negedge clk);
        mem_valid = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        checks++;
        if ({ls_ack, if_ack, ls_err, ls_rdata} !== {1'b1, 1'b0, 1'b0, 32'h5A5A}) begin
            errors++;
            $display("FAIL store_ack: got ls_ack=%b if_ack=%b err=%b rdata=%h exp 1 0 0 5a5a", ls_ack, if_ack, ls_err, ls_rdata);
        end
        @(negedge clk);
        checks++;
        if (ls_ack !== 1'b0) begin
            errors++;
            $display("FAIL store_ack_pulse: got ls_ack=%b exp 0", ls_ack);
        end
    endtask

    task automatic test_stray_valid();
        mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem_req, if_ack, ls_ack, if_rdata, ls_rdata} !== {3'b000, 32'h13, 32'h5A5A}) begin
                errors++;
                $display("FAIL stray_valid[%0d]: got req=%b acks=%b%b if=%h ls=%h exp 0 00 13 5a5a", i, mem_req, if_ack, ls_ack, if_rdata, ls_rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        bit exp_ls;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; ls_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            exp_ls = (k % 2 == 0);
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, (exp_ls ? 32'h2000 : 32'h1000)}) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got req=%b addr=%h exp_ls=%b", k, mem_req, mem_addr, exp_ls);
            end
            mem_valid = 1'b1; mem_rdata = W'(k);
            @(negedge clk);
            mem_valid = 1'b0;
            checks++;
            if ({if_ack, ls_ack} !== (exp_ls ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL contention_ack[%0d]: got if_ack=%b ls_ack=%b exp_ls=%b", k, if_ack, ls_ack, exp_ls);
            end
            if (exp_ls) ls_req = 1'b0; else if_req = 1'b0;
            @(negedge clk);
            if (k < 3) begin
                if (exp_ls) ls_req = 1'b1; else if_req = 1'b1;
            end else begin
                if_req = 1'b0; ls_req = 1'b0;
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        if_req = 1'b1; if_addr = 32'h4000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL timeout_busy_len: got %0d cycles exp %0d", n, TO);
        end
        checks++;
        if ({if_ack, if_err, ls_ack, if_rdata} !== {3'b110, 32'h0}) begin
            errors++;
            $display("FAIL timeout_resp: got ack=%b err=%b ls_ack=%b rdata=%h exp 1 1 0 0", if_ack, if_err, ls_ack, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_ack, if_err} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_err_hold: got ack=%b err=%b exp 0 1", if_ack, if_err);
        end
        if_req = 1'b1; if_addr = 32'h4004;
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_valid = 1'b0; if_req = 1'b0;
        checks++;
        if ({if_ack, if_err, if_rdata} !== {2'b10, 32'h77}) begin
            errors++;
            $display("FAIL timeout_recover: got ack=%b err=%b rdata=%h exp 1 0 77", if_ack, if_err, if_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        if_req = 1'b1; if_addr = 32'h5000;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h5000}) begin
            errors++;
            $display("FAIL rst_busy_pre: got req=%b addr=%h exp 1 5000", mem_req, mem_addr);
        end
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h99;
        checks++;
        if ({mem_req, mem_we, if_ack, ls_ack, if_err, ls_err, mem_addr, mem_wdata, if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_busy_clear: got req=%b we=%b acks=%b%b errs=%b%b addr=%h wdata=%h if=%h ls=%h exp all 0",
                     mem_req, mem_we, if_ack, ls_ack, if_err, ls_err, mem_addr, mem_wdata, if_rdata, ls_rdata);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        checks++;
        if ({mem_req, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_busy_after: got req=%b acks=%b%b errs=%b%b if=%h ls=%h exp all 0",
                     mem_req, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata);
        end
    endtask

    // Transaction-level model: pending set, round-robin pointer, per-port result registers
    task automatic test_random();
        bit           pend [2];
        logic [W-1:0] m_rdata [2];
        bit           m_err [2];
        bit           m_last;
        bit           g;
        logic         e_we;
        logic [W-1:0] e_addr, e_wdata;
        int           d;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        m_last = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if (!pend[0] && $urandom_range(0, 1) == 1) begin
                pend[0] = 1'b1; if_addr = $urandom;
            end
            if (!pend[1] && $urandom_range(0, 1) == 1) begin
                pend[1] = 1'b1; ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom_range(0, 1));
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1; if_addr = $urandom;
            end
            if_req = pend[0]; ls_req = pend[1];
            mem_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            g = (pend[0] && pend[1]) ? !m_last : pend[1];
            m_last  = g;
            e_addr  = g ? ls_addr : if_addr;
            e_we    = g ? ls_we : 1'b0;
            e_wdata = g ? ls_wdata : '0;
            d = $urandom_range(0, TO);
            for (int i = 0; i < TO; i++) begin
                @(negedge clk);
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, e_we, e_addr, e_wdata}) begin
                    errors++;
                    $display("FAIL rnd_busy it=%0d cyc=%0d: got req=%b we=%b addr=%h wdata=%h exp 1 %b %h %h",
                             it, i, mem_req, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
                end
                if (!pend[0]) if_addr = $urandom;
                if (!pend[1]) begin
                    ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom_range(0, 1));
                end
                mem_valid = (i == d); mem_rdata = $urandom;
                if (i == d) begin
                    m_rdata[g] = mem_rdata; m_err[g] = 1'b0;
                    break;
                end
            end
            if (d == TO) begin
                m_rdata[g] = '0; m_err[g] = 1'b1;
            end
            @(negedge clk);
            checks++;
            if ({mem_req, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata} !==
                {1'b0, !g, g, m_err[0], m_err[1], m_rdata[0], m_rdata[1]}) begin
                errors++;
                $display("FAIL rnd_resp it=%0d: got req=%b acks=%b%b errs=%b%b if=%h ls=%h exp 0 %b%b %b%b %h %h",
                         it, mem_req, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata,
                         !g, g, m_err[0], m_err[1], m_rdata[0], m_rdata[1]);
            end
            pend[g] = 1'b0;
            if_req = pend[0]; ls_req = pend[1];
            mem_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            @(negedge clk);
            mem_valid = 1'b0;
            checks++;
            if ({mem_req, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata} !==
                {3'b000, m_err[0], m_err[1], m_rdata[0], m_rdata[1]}) begin
                errors++;
                $display("FAIL rnd_idle it=%0d: got req=%b acks=%b%b errs=%b%b if=%h ls=%h exp 0 00 %b%b %h %h",
                         it, mem_req, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata,
                         m_err[0], m_err[1], m_rdata[0], m_rdata[1]);
            end
        end
        if_req = 1'b0; ls_req = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_store();
        test_stray_valid();
        test_contention();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: address and data width.
REQ-002 Parameter TIMEOUT, default 16: maximum BUSY cycles before a transaction is abandoned; legal range 2..255.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 if_req  input  1: instruction-fetch request, held until if_ack.
REQ-006 if_addr  input  WIDTH: fetch address, stable while if_req is high.
REQ-007 if_ack  output  1: one-cycle fetch completion pulse.
REQ-008 if_err  output  1: fetch timed out; valid only with if_ack.
REQ-009 if_rdata  output  WIDTH: fetched word; valid with if_ack.
REQ-010 ls_req  input  1: load/store request, held until ls_ack.
REQ-011 ls_we  input  1: 1 means store, 0 means load; stable while ls_req is high.
REQ-012 ls_addr  input  WIDTH: load/store address.
REQ-013 ls_wdata  input  WIDTH: store data.
REQ-014 ls_ack  output  1: one-cycle load/store completion pulse.
REQ-015 ls_err  output  1: load/store timed out; valid only with ls_ack.
REQ-016 ls_rdata  output  WIDTH: load data; valid with ls_ack.
REQ-017 mem_req  output  1: memory transaction active.
REQ-018 mem_we  output  1: memory write enable.
REQ-019 mem_addr  output  WIDTH: memory address.
REQ-020 mem_wdata  output  WIDTH: memory write data.
REQ-021 mem_rdata  input  WIDTH: memory read data; sampled when mem_valid is high.
REQ-022 mem_valid  input  1: memory completion, one cycle.

Function
REQ-023 The FSM SHALL have states IDLE, BUSY and RESP, plus a registered owner bit (0 = IF, 1 = LS) and a registered last_grant bit.
REQ-024 In IDLE, a pending request SHALL cause transition to BUSY on the next edge.
- Only one request pending: that requester is granted.
- Both pending: the requester not equal to last_grant is granted (round-robin).
REQ-025 On each grant, the block SHALL latch owner, last_grant, address, we and wdata into registers.
- IF grants force the latched we to 0 and wdata to 0.
REQ-026 mem_req SHALL be 1 exactly while the state is BUSY; mem_addr, mem_we and mem_wdata SHALL come only from the latched registers.
REQ-027 In BUSY, mem_valid=1 SHALL cause transition to RESP, capture mem_rdata into the owner's rdata register, and clear the owner's err.
REQ-028 A BUSY cycle counter SHALL clear on entry to BUSY.
- If TIMEOUT BUSY cycles elapse without mem_valid, the FSM transitions to RESP.
- The owner's err is set to 1 and the owner's rdata to 0.
REQ-029 mem_valid arriving in the same cycle as the timeout threshold SHALL count as success, not a timeout.
REQ-030 RESP SHALL last exactly one cycle: the owner's ack is 1, the other ack is 0, then the FSM returns to IDLE.
REQ-031 Latency: request seen in IDLE at cycle N gives mem_req in N+1; mem_valid at cycle M gives ack at M+1 and IDLE at M+2.
REQ-032 Requesters SHALL drop req by the cycle after ack.
- A request still high in IDLE at M+2 is treated as a new request.
REQ-033 mem_valid while in IDLE or RESP SHALL be ignored: no state, rdata or err change.
REQ-034 Input changes on a non-granted port during BUSY or RESP SHALL NOT affect the memory outputs.
REQ-035 rdata and err SHALL hold their last values between acks.

Reset
REQ-036 rst=1 at a clock edge SHALL force all of the following, regardless of current state, including mid-BUSY:
- state IDLE, owner 0, last_grant 0, counter 0;
- mem_req, mem_we, if_ack, ls_ack, if_err and ls_err all 0;
- mem_addr, mem_wdata, if_rdata and ls_rdata all 0.
REQ-037 A transaction interrupted by reset SHALL produce no ack; mem_valid arriving after reset SHALL be ignored.
REQ-038 The first simultaneous request after reset SHALL grant LS, because last_grant resets to 0.

Verification
REQ-039 IF only: if_req=1, if_addr=0x3000, mem_valid 2 cycles after mem_req with mem_rdata=0x00000013 -> mem_we=0, if_ack one cycle with if_rdata=0x13, if_err=0, ls_ack=0.
REQ-040 Store: ls_req=1, ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF -> mem_req with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; mem_valid -> ls_ack next cycle.
REQ-041 Contention: if_req and ls_req high together from reset, each re-asserted after its ack -> grant order LS, IF, LS, IF; no requester is granted twice in a row.
REQ-042 Timeout: TIMEOUT=4, if_req with mem_valid never asserted -> mem_req high for exactly 4 cycles, then if_ack=1, if_err=1, if_rdata=0; the next IF transaction clears if_err.
REQ-043 Reset mid-BUSY: rst=1 for one cycle during BUSY, then mem_valid=1 -> mem_req=0 on the cycle after the rst edge; no ack; all outputs at their reset values.
REQ-044 Stray mem_valid=1 in IDLE with mem_rdata=0xFFFFFFFF -> if_rdata and ls_rdata unchanged; no ack.
